uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range >= 2.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 Parameter MSB_FIRST, default 0: 0 sends the data LSB first, 1 sends it MSB first.
REQ-006 Port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port tx_data, input, DATA_W bits: payload, sampled only on acceptance.
REQ-009 Port tx_valid, input, 1 bit: the producer offers tx_data.
REQ-010 Port tx_ready, output, 1 bit: the block can accept a frame.
REQ-011 Port tx_out, output, 1 bit: registered serial line, idle high.
REQ-012 Port busy, output, 1 bit: a frame is in progress.
REQ-013 Port tx_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-015 tx_ready SHALL equal (state == IDLE), with no dependency on tx_valid.
REQ-016 A frame is accepted at a rising edge where tx_valid && tx_ready; at that edge the block SHALL load tx_data into the shift register, compute parity, clear the bit counter and enter START.
REQ-017 tx_valid while tx_ready=0 SHALL be ignored; it SHALL cause no state change and no data capture.
REQ-018 Each serial bit SHALL drive tx_out for exactly CLKS_PER_BIT cycles, timed by an internal bit-period counter that restarts at every bit boundary.
REQ-019 Bit order SHALL be: start bit (0); DATA_W data bits (order per MSB_FIRST); parity bit only if PARITY != 0; then STOP_BITS stop bits (1).
REQ-020 The frame length is N = 1 + DATA_W + (PARITY != 0) + STOP_BITS bits.
REQ-021 Even parity: the parity bit makes the total count of ones in data plus parity even; odd parity makes that total odd.
REQ-022 The parity bit SHALL be computed from the accepted data, not from the shifting register.
REQ-023 Transitions:
- START -> DATA after 1 bit period.
- DATA -> PAR, or -> STOP when PARITY = 0, after DATA_W bit periods.
- PAR -> STOP after 1 bit period.
- STOP -> IDLE after STOP_BITS bit periods.
REQ-024 If acceptance occurs at edge k, tx_out SHALL be 0 from edge k, and the block SHALL return to IDLE at edge k + N*CLKS_PER_BIT.
REQ-025 tx_done SHALL be 1 for exactly the one cycle following the edge that returns the block to IDLE.
REQ-026 Back-to-back frames: a new frame accepted in the same cycle that tx_done=1 SHALL start its start bit at the next edge, with no extra idle cycles.
REQ-027 busy SHALL equal !tx_ready.
REQ-028 tx_out SHALL be 1 in IDLE.

Reset
REQ-029 At a rising edge with rst=1, the block SHALL set state=IDLE, tx_out=1, tx_done=0, and clear all counters and the shift register.
REQ-030 A reset mid-frame SHALL abort the frame: the line returns high at that edge, and the data is discarded with no tx_done pulse.
REQ-031 rst SHALL take priority over a simultaneous tx_valid.

Structure
REQ-032 The shared package uart_pkg SHALL hold the state enum and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-033 A single sub-module, uart_shift_reg, SHALL implement the parametrised parallel-load shift register:
- inputs: load, shift, msb_first;
- DATA_W wide;
- zero fill on shift.
REQ-034 The bit-period counter, bit counter and FSM SHALL reside in uart_tx_serializer.

Verification (bench uses CLKS_PER_BIT=4, DATA_W=8 unless stated)
REQ-035 Case PARITY=0, STOP_BITS=1, send 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulses 40 cycles after acceptance.
REQ-036 Case PARITY=1, send 0xA5 -> parity bit 0; same data with PARITY=2 -> parity bit 1; frame length 44 cycles.
REQ-037 Case MSB_FIRST=1, STOP_BITS=2, send 0x80 -> data bits 1,0,0,0,0,0,0,0; two stop bits; tx_ready rises 44 cycles after acceptance.
REQ-038 Case tx_valid held high, 0x11 then 0x22 -> the second start bit begins on the edge right after tx_done; no idle gap.
REQ-039 Case tx_valid pulsed with 0xFF during the DATA state of frame 0x00 -> ignored; only 0x00 is transmitted.
REQ-040 Case rst asserted 10 cycles into a frame -> tx_out=1, tx_ready=1, tx_done=0 after that edge; the next frame sends correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the frame FSM state encoding, the parity-mode codes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest payload the serializer supports; narrower payloads are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int DATA_MAX_W = 9;

  function automatic logic parity_bit(input logic [DATA_MAX_W-1:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_shift_reg.sv
// Parallel-load shift register feeding the serial line, one bit per shift.
// Direction is selectable; vacated positions are filled with zeros.
module uart_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              msb_first,
  input  logic [DATA_W-1:0] din,
  output logic              ser_bit
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= din;
    end else if (shift) begin
      r_data <= msb_first ? {r_data[DATA_W-2:0], 1'b0} : {1'b0, r_data[DATA_W-1:1]};
    end
  end

  // The bit currently at the head of the register is the next one to transmit.
  assign ser_bit = msb_first ? r_data[DATA_W-1] : r_data[0];

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a word on a valid/ready handshake and sends
// start, data, optional parity and stop bits, each held CLKS_PER_BIT cycles.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int CLK_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_CNT_W = $clog2(DATA_W + 1);

  uart_state_e r_state;
  uart_state_e w_state_next;

  logic [CLK_CNT_W-1:0]  r_clk_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_parity;
  logic                  r_tx_out;
  logic                  r_tx_done;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_bit_end;
  logic                  w_last_data;
  logic                  w_last_stop;
  logic                  w_shift;
  logic                  w_sr_bit;
  logic                  w_tx_out_next;
  logic                  w_tx_done_next;
  logic                  w_parity_next;
  logic [DATA_MAX_W-1:0] w_data_ext;

  assign w_ready     = (r_state == IDLE);
  assign w_accept    = tx_valid && w_ready;
  assign w_bit_end   = (r_clk_cnt == CLK_CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_data = (r_bit_cnt == BIT_CNT_W'(DATA_W - 1));
  assign w_last_stop = (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1));

  // Parity comes from the word as accepted, so it is latched alongside the load.
  always_comb begin
    w_data_ext = '0;
    w_data_ext[DATA_W-1:0] = tx_data;
    w_parity_next = parity_bit(w_data_ext, PARITY);
  end

  uart_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_accept),
    .shift    (w_shift),
    .msb_first(MSB_FIRST != 0),
    .din      (tx_data),
    .ser_bit  (w_sr_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (tx_valid) w_state_next = START;
      START: if (w_bit_end) w_state_next = DATA;
      DATA:  if (w_bit_end && w_last_data) w_state_next = (PARITY != PAR_NONE) ? PAR : STOP;
      PAR:   if (w_bit_end) w_state_next = STOP;
      STOP:  if (w_bit_end && w_last_stop) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // tx_out is registered, so each boundary drives the value of the bit being entered.
  always_comb begin
    w_shift        = 1'b0;
    w_tx_out_next  = r_tx_out;
    w_tx_done_next = 1'b0;
    case (r_state)
      IDLE: w_tx_out_next = ~w_accept;
      START: begin
        if (w_bit_end) begin
          w_tx_out_next = w_sr_bit;
          w_shift       = 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (w_last_data) begin
            w_tx_out_next = (PARITY != PAR_NONE) ? r_parity : 1'b1;
          end else begin
            w_tx_out_next = w_sr_bit;
            w_shift       = 1'b1;
          end
        end
      end
      PAR:  if (w_bit_end) w_tx_out_next = 1'b1;
      STOP: if (w_bit_end && w_last_stop) w_tx_done_next = 1'b1;
      default: w_tx_out_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_tx_out  <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_out  <= w_tx_out_next;
      r_tx_done <= w_tx_done_next;
      if (w_accept) begin
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
        r_parity  <= w_parity_next;
      end else if (r_state != IDLE) begin
        if (w_bit_end) begin
          r_clk_cnt <= '0;
          r_bit_cnt <= (w_state_next != r_state) ? '0 : r_bit_cnt + 1'b1;
        end else begin
          r_clk_cnt <= r_clk_cnt + 1'b1;
        end
      end
    end
  end

  assign tx_ready = w_ready;
  assign busy     = ~w_ready;
  assign tx_out   = r_tx_out;
  assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized scoreboard bench for uart_tx_serializer over four frame formats.
// Stimulus queues expected words; a per-format monitor rebuilds each frame from the line.
module tb_uart_tx_serializer;

  localparam int CPB  = 4;
  localparam int DW   = 8;
  localparam int NCFG = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       imm;
    logic       abort;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int P    = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
    localparam int SB   = (gi == 3) ? 2 : 1;
    localparam int MF   = (gi == 3) ? 1 : 0;
    localparam int NB   = 1 + DW + ((P != 0) ? 1 : 0) + SB;
    localparam int FLEN = NB * CPB;
    localparam logic [7:0] FIRST_WORD = (gi == 3) ? 8'h80 : 8'hA5;

    logic          rst;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          tx_out;
    logic          busy;
    logic          tx_done;
    exp_t          sb_q[$];

    uart_tx_serializer #(
      .DATA_W      (DW),
      .CLKS_PER_BIT(CPB),
      .PARITY      (P),
      .STOP_BITS   (SB),
      .MSB_FIRST   (MF)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_out  (tx_out),
      .busy    (busy),
      .tx_done (tx_done)
    );

    // Reference: value of serial bit i of the frame carrying word d.
    function automatic logic model_bit(input logic [7:0] d, input int i);
      logic par;
      int   di;
      par = (($countones(d) % 2) == 1);
      if (P == 2) par = ~par;
      if (i == 0) return 1'b0;
      if (i <= DW) begin
        di = i - 1;
        return (MF != 0) ? d[DW-1-di] : d[di];
      end
      if (P != 0 && i == DW + 1) return par;
      return 1'b1;
    endfunction

    task automatic chk(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cfg%0d %s got=%b want=%b", gi, name, got, want);
      end
    endtask

    task automatic send(input logic [7:0] d, input logic imm, input logic keep, input logic abort);
      int   waited;
      exp_t e;
      waited  = 0;
      e.data  = d;
      e.imm   = imm;
      e.abort = abort;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && waited < 4 * FLEN) begin
        @(posedge clk);
        #1;
        waited++;
      end
      if (!tx_ready) begin
        checks++;
        errors++;
        $display("FAIL cfg%0d accept_timeout data=%02h tx_ready=%b want=1", gi, d, tx_ready);
        tx_valid = 1'b0;
        return;
      end
      sb_q.push_back(e);
      $display("cfg%0d send data=%02h imm=%0d abort=%0d", gi, d, imm, abort);
      @(posedge clk);
      #1;
      if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int w;
      w = 0;
      while (!tx_ready && w < 2 * FLEN) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk("idle_timeout", tx_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1;
    endtask

    initial begin : stim
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_tx_out", tx_out, 1'b1);
      chk("reset_tx_ready", tx_ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_tx_done", tx_done, 1'b0);

      send(FIRST_WORD, 1'b0, 1'b0, 1'b0);

      // Valid held high across two words: second must start right after tx_done.
      send(8'h11, 1'b0, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b0, 1'b0);

      // A valid pulse while busy must neither start a frame nor alter the data.
      send(8'h00, 1'b0, 1'b0, 1'b0);
      repeat (12) @(posedge clk);
      #1;
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = '0;
      wait_idle();

      // Reset wins over a simultaneous valid.
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      tx_valid = 1'b0;
      chk("rst_prio_tx_ready", tx_ready, 1'b1);
      chk("rst_prio_tx_out", tx_out, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Reset ten cycles into a frame aborts it; the following frame is clean.
      send(8'h3C, 1'b0, 1'b0, 1'b1);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_tx_out", tx_out, 1'b1);
      chk("abort_tx_ready", tx_ready, 1'b1);
      chk("abort_tx_done", tx_done, 1'b0);
      send(8'hC3, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 10; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send(8'($urandom), 1'b0, 1'b0, 1'b0);
      end
      send(8'($urandom), 1'b0, 1'b1, 1'b0);
      send(8'($urandom), 1'b1, 1'b0, 1'b0);

      repeat (FLEN + 10) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain pending=%0d want=0", gi, sb_q.size());
      end
      done_cnt++;
    end

    initial begin : mon
      logic prev_busy;
      int   gap;
      int   lim;
      int   bad_c;
      int   w;
      logic ok;
      logic got_b;
      logic want_b;
      exp_t e;
      prev_busy = 1'b0;
      gap       = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_busy = 1'b0;
          gap       = 0;
          continue;
        end
        checks++;
        if (busy !== ~tx_ready) begin
          errors++;
          $display("FAIL cfg%0d busy_vs_ready busy=%b want=%b", gi, busy, ~tx_ready);
        end
        if (busy && !prev_busy) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg%0d unexpected_frame busy=1 want=0", gi);
            w = 0;
            while (busy && w < FLEN + 8) begin
              @(negedge clk);
              w++;
            end
            prev_busy = busy;
            continue;
          end
          e = sb_q.pop_front();
          if (e.imm) begin
            checks++;
            if (gap != 0) begin
              errors++;
              $display("FAIL cfg%0d b2b_gap data=%02h idle_cycles=%0d want=0", gi, e.data, gap);
            end
          end
          lim    = e.abort ? 10 : FLEN;
          ok     = 1'b1;
          bad_c  = -1;
          got_b  = 1'b0;
          want_b = 1'b0;
          for (int c = 0; c < lim; c++) begin
            if (c > 0) @(negedge clk);
            if (ok && (tx_out !== model_bit(e.data, c / CPB) || tx_ready !== 1'b0 || tx_done !== 1'b0)) begin
              ok     = 1'b0;
              bad_c  = c;
              got_b  = tx_out;
              want_b = model_bit(e.data, c / CPB);
            end
          end
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL cfg%0d frame data=%02h cycle=%0d tx_out=%b want=%b tx_ready=%b tx_done=%b want 0/0",
                     gi, e.data, bad_c, got_b, want_b, tx_ready, tx_done);
          end
          @(negedge clk);
          checks++;
          if (e.abort) begin
            if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
              errors++;
              $display("FAIL cfg%0d abort_end out/ready/done=%b%b%b want=110", gi, tx_out, tx_ready, tx_done);
            end
          end else begin
            if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b1) begin
              errors++;
              $display("FAIL cfg%0d frame_end data=%02h out/ready/done=%b%b%b want=111",
                       gi, e.data, tx_out, tx_ready, tx_done);
            end
          end
          $display("cfg%0d frame data=%02h abort=%0d checked ok=%0d", gi, e.data, e.abort, ok);
          gap       = 0;
          prev_busy = busy;
        end else begin
          if (!busy) begin
            checks++;
            if (tx_done !== 1'b0) begin
              errors++;
              $display("FAIL cfg%0d spurious_done tx_done=%b want=0", gi, tx_done);
            end
            gap++;
          end
          prev_busy = busy;
        end
      end
    end
  end

  initial begin : watchdog
    int cyc;
    cyc = 0;
    while (done_cnt < NCFG && cyc < 50000) begin
      @(posedge clk);
      cyc++;
    end
    if (done_cnt < NCFG) begin
      checks++;
      errors++;
      $display("FAIL timeout finished=%0d want=%0d", done_cnt, NCFG);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
